// File: rtl/req_encoder_pkg.sv
// Shared constants, FSM state type and priority helper for req_encoder.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package req_encoder_pkg;

  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;

  // iEna value (G1=1, G2=0) that enables presentation
  localparam logic [1:0] ENABLE = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_t;

  // Index of the highest set bit; bit N_REQ-1 has top priority.
  function automatic logic [CODE_W-1:0] hi_index(input logic [N_REQ-1:0] v);
    hi_index = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (v[i]) hi_index = CODE_W'(i);
    end
  endfunction

endpackage

// File: rtl/req_encoder_if.sv
// Request/code bundle between request sources, req_encoder and its consumer.
// Latency: n/a (wiring only).
// Backpressure: oValid/iAck handshake; a code is held until acknowledged.
interface req_encoder_if;
  import req_encoder_pkg::*;

  logic [N_REQ-1:0]  iReq;
  logic [1:0]        iEna;
  logic              iAck;
  logic              iClrOvr;
  logic [CODE_W-1:0] oCode;
  logic              oValid;
  logic [N_REQ-1:0]  oPending;
  logic              oBusy;
  logic [N_REQ-1:0]  oOverrun;

  // Request sources and consumer side
  modport master (
    output iReq, iEna, iAck, iClrOvr,
    input  oCode, oValid, oPending, oBusy, oOverrun
  );

  // Encoder side
  modport slave (
    input  iReq, iEna, iAck, iClrOvr,
    output oCode, oValid, oPending, oBusy, oOverrun
  );

endinterface

// File: rtl/req_encoder_sync_fall_detect.sv
// N-wide synchronizer for active-low async lines plus falling-edge detector.
// Latency: fall[i] is high SYNC_STAGES-1 cycles after the first edge sampling low.
// Backpressure: none; one-cycle fall pulse per high-to-low transition.
module sync_fall_detect #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_n,
  output logic [N-1:0] fall
);

  logic [SYNC_STAGES-1:0][N-1:0] sync_q, sync_d;
  logic [N-1:0]                  prev_q, prev_d;

  // Shift chain: stage 0 samples the pins, prev holds the last stage one cycle back
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], req_n};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Reset to all-ones so idle-high lines never look like a falling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= '1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign fall = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/req_encoder.sv
// 8-to-3 priority request encoder: latches falling edges, presents highest pending index.
// Latency: oValid visible in the cycle after edge k+SYNC_STAGES+1 (k = first edge sampling low).
// Backpressure: code held until iAck; one-cycle valid gap between codes. Optional REQ_ENCODER_OVERRUN_EN.
module req_encoder
  import req_encoder_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic          iClk,
  input  logic          iRst_n,
  req_encoder_if.slave  bus
);

  logic [N_REQ-1:0]  fall;
  logic              enabled;
  state_t            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic [N_REQ-1:0]  pending_q, pending_d;
  logic              busy_q, busy_d;

  sync_fall_detect #(
    .N           (N_REQ),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (iClk),
    .rst_n (iRst_n),
    .req_n (bus.iReq),
    .fall  (fall)
  );

  // FSM next state, pending update (new edges win over the ack clear), busy
  always_comb begin
    enabled   = (bus.iEna == ENABLE);
    state_d   = state_q;
    code_d    = code_q;
    valid_d   = valid_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        if (enabled && (pending_q != '0)) begin
          code_d  = hi_index(pending_q);
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (bus.iAck) begin
          pending_d = pending_q & ~(N_REQ'(1) << code_q);
          valid_d   = 1'b0;
          state_d   = GAP;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
    pending_d = pending_d | fall;
    busy_d    = |pending_d;
  end

  // State and all registered outputs
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q   <= IDLE;
      code_q    <= '0;
      valid_q   <= 1'b0;
      pending_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.oCode    = code_q;
  assign bus.oValid   = valid_q;
  assign bus.oPending = pending_q;
  assign bus.oBusy    = busy_q;

`ifdef REQ_ENCODER_OVERRUN_EN
  logic [N_REQ-1:0] ovr_q, ovr_d;

  // Sticky overrun: edge on an already-pending line; a new overrun beats the clear
  always_comb begin
    ovr_d = (bus.iClrOvr ? '0 : ovr_q) | (fall & pending_q);
  end

  // Overrun flag register
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      ovr_q <= '0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign bus.oOverrun = ovr_q;
`else
  logic unused_clr_ovr;
  assign unused_clr_ovr = bus.iClrOvr;
  assign bus.oOverrun   = '0;
`endif

endmodule

// File: tb/tb_req_encoder.sv
// Directed-vector bench for req_encoder: table of per-cycle stimulus/expectations
// plus hand-written sequences for overrun and asynchronous reset mid-presentation.
// Expectations for oOverrun follow whether REQ_ENCODER_OVERRUN_EN is defined.
module tb_req_encoder;
  import req_encoder_pkg::*;

`ifdef REQ_ENCODER_OVERRUN_EN
  localparam bit OVR_ON = 1'b1;
`else
  localparam bit OVR_ON = 1'b0;
`endif

  logic iClk = 1'b0;
  logic iRst_n = 1'b0;

  req_encoder_if ifc();

  req_encoder #(.SYNC_STAGES(2)) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .bus    (ifc)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [7:0] req;
    logic [1:0] ena;
    logic       ack;
    logic       clr;
    logic       v;
    logic [2:0] c;
    logic [7:0] p;
    logic [7:0] ovr;
  } vec_t;

  vec_t vq[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic add(input logic [7:0] req, input logic [1:0] ena, input logic ack,
                     input logic clr, input logic v, input logic [2:0] c,
                     input logic [7:0] p, input logic [7:0] ovr);
    vec_t t;
    t.req = req; t.ena = ena; t.ack = ack; t.clr = clr;
    t.v = v; t.c = c; t.p = p; t.ovr = ovr;
    vq.push_back(t);
  endtask

  // Apply inputs just after an edge, let one rising edge pass, settle 1ns
  task automatic drive(input logic [7:0] req, input logic [1:0] ena,
                       input logic ack, input logic clr);
    ifc.iReq    = req;
    ifc.iEna    = ena;
    ifc.iAck    = ack;
    ifc.iClrOvr = clr;
    @(posedge iClk);
    #1;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({ifc.oValid, ifc.oCode, ifc.oPending, ifc.oBusy, ifc.oOverrun});
  endfunction

  function automatic logic [31:0] expo(input logic v, input logic [2:0] c,
                                      input logic [7:0] p, input logic [7:0] ovr);
    return 32'({v, c, p, (p != 8'h00), (OVR_ON ? ovr : 8'h00)});
  endfunction

  initial begin
    // A: line 5 falls, latency, ack, no re-present while held low
    add(8'hDF, 2'b10, 0, 0, 0, 3'd0, 8'h00, 8'h00);
    add(8'hDF, 2'b10, 0, 0, 0, 3'd0, 8'h00, 8'h00);
    add(8'hDF, 2'b10, 0, 0, 0, 3'd0, 8'h20, 8'h00);
    add(8'hDF, 2'b10, 0, 0, 1, 3'd5, 8'h20, 8'h00);
    add(8'hDF, 2'b10, 1, 0, 0, 3'd5, 8'h00, 8'h00);
    add(8'hDF, 2'b10, 0, 0, 0, 3'd5, 8'h00, 8'h00);
    add(8'hDF, 2'b10, 0, 0, 0, 3'd5, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) add(8'hFF, 2'b10, 0, 0, 0, 3'd5, 8'h00, 8'h00);
    // B: lines 2 and 6 together -> 6 first, then 2 after the gap
    add(8'hBB, 2'b10, 0, 0, 0, 3'd5, 8'h00, 8'h00);
    add(8'hBB, 2'b10, 0, 0, 0, 3'd5, 8'h00, 8'h00);
    add(8'hBB, 2'b10, 0, 0, 0, 3'd5, 8'h44, 8'h00);
    add(8'hBB, 2'b10, 0, 0, 1, 3'd6, 8'h44, 8'h00);
    add(8'hBB, 2'b10, 0, 0, 1, 3'd6, 8'h44, 8'h00);
    add(8'hBB, 2'b10, 1, 0, 0, 3'd6, 8'h04, 8'h00);
    add(8'hBB, 2'b10, 0, 0, 0, 3'd6, 8'h04, 8'h00);
    add(8'hBB, 2'b10, 0, 0, 1, 3'd2, 8'h04, 8'h00);
    add(8'hBB, 2'b10, 1, 0, 0, 3'd2, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) add(8'hFF, 2'b10, 0, 0, 0, 3'd2, 8'h00, 8'h00);
    // C: disabled capture, ack ignored in IDLE, then enable presents
    add(8'hFD, 2'b11, 0, 0, 0, 3'd2, 8'h00, 8'h00);
    add(8'hFD, 2'b11, 0, 0, 0, 3'd2, 8'h00, 8'h00);
    add(8'hFD, 2'b11, 0, 0, 0, 3'd2, 8'h02, 8'h00);
    add(8'hFD, 2'b11, 1, 0, 0, 3'd2, 8'h02, 8'h00);
    add(8'hFD, 2'b10, 0, 0, 1, 3'd1, 8'h02, 8'h00);
    add(8'hFD, 2'b10, 1, 0, 0, 3'd1, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) add(8'hFF, 2'b10, 0, 0, 0, 3'd1, 8'h00, 8'h00);
    // D: line 3 presented, held while disabled, re-fall lands on the ack cycle
    add(8'hF7, 2'b10, 0, 0, 0, 3'd1, 8'h00, 8'h00);
    add(8'hF7, 2'b10, 0, 0, 0, 3'd1, 8'h00, 8'h00);
    add(8'hF7, 2'b10, 0, 0, 0, 3'd1, 8'h08, 8'h00);
    add(8'hF7, 2'b10, 0, 0, 1, 3'd3, 8'h08, 8'h00);
    add(8'hF7, 2'b11, 0, 0, 1, 3'd3, 8'h08, 8'h00);
    add(8'hFF, 2'b11, 0, 0, 1, 3'd3, 8'h08, 8'h00);
    add(8'hFF, 2'b11, 0, 0, 1, 3'd3, 8'h08, 8'h00);
    add(8'hF7, 2'b11, 0, 0, 1, 3'd3, 8'h08, 8'h00);
    add(8'hF7, 2'b11, 0, 0, 1, 3'd3, 8'h08, 8'h00);
    add(8'hF7, 2'b10, 1, 0, 0, 3'd3, 8'h08, 8'h08);
    add(8'hF7, 2'b10, 0, 0, 0, 3'd3, 8'h08, 8'h08);
    add(8'hF7, 2'b10, 0, 0, 1, 3'd3, 8'h08, 8'h08);
    add(8'hF7, 2'b10, 1, 1, 0, 3'd3, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) add(8'hFF, 2'b10, 0, 0, 0, 3'd3, 8'h00, 8'h00);

    // Reset state
    ifc.iReq = 8'hFF; ifc.iEna = 2'b10; ifc.iAck = 1'b0; ifc.iClrOvr = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    cmp("reset_outputs", outs(), expo(0, 3'd0, 8'h00, 8'h00));
    iRst_n = 1'b1;
    drive(8'hFF, 2'b10, 0, 0);
    drive(8'hFF, 2'b10, 0, 0);
    cmp("idle_after_release", outs(), expo(0, 3'd0, 8'h00, 8'h00));

    foreach (vq[i]) begin
      drive(vq[i].req, vq[i].ena, vq[i].ack, vq[i].clr);
      cmp($sformatf("row%0d {v,code,pend,busy,ovr}", i), outs(),
          expo(vq[i].v, vq[i].c, vq[i].p, vq[i].ovr));
    end

    // Overrun: line 0 pulsed twice without ack, then cleared
    repeat (3) drive(8'hFE, 2'b10, 0, 0);
    repeat (3) drive(8'hFF, 2'b10, 0, 0);
    cmp("ovr_presenting0", 32'({ifc.oValid, ifc.oCode}), 32'({1'b1, 3'd0}));
    drive(8'hFE, 2'b10, 0, 0);
    drive(8'hFE, 2'b10, 0, 0);
    cmp("ovr_before_second_edge", 32'(ifc.oOverrun), 32'h00);
    drive(8'hFE, 2'b10, 0, 0);
    cmp("ovr_set", 32'(ifc.oOverrun), OVR_ON ? 32'h01 : 32'h00);
    cmp("ovr_no_preempt", 32'({ifc.oValid, ifc.oCode, ifc.oPending}), 32'({1'b1, 3'd0, 8'h01}));
    drive(8'hFE, 2'b10, 0, 1);
    cmp("ovr_cleared", 32'(ifc.oOverrun), 32'h00);
    drive(8'hFE, 2'b10, 1, 0);
    cmp("ovr_ack_pending", 32'({ifc.oValid, ifc.oPending, ifc.oBusy}), 32'({1'b0, 8'h00, 1'b0}));
    repeat (4) drive(8'hFF, 2'b10, 0, 0);

    // Asynchronous reset while presenting code 4
    repeat (4) drive(8'hEF, 2'b10, 0, 0);
    cmp("pre_reset_present4", 32'({ifc.oValid, ifc.oCode, ifc.oPending}), 32'({1'b1, 3'd4, 8'h10}));
    #2;
    iRst_n = 1'b0;
    ifc.iReq = 8'hFF;
    #1;
    cmp("async_reset_outputs", outs(), expo(0, 3'd0, 8'h00, 8'h00));
    @(posedge iClk);
    #3;
    iRst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(8'hFF, 2'b10, 0, 0);
      cmp($sformatf("post_reset_idle%0d", i), outs(), expo(0, 3'd0, 8'h00, 8'h00));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/req_encoder.md
Name: req_encoder

Overview:
- Sequential 8-to-3 priority request encoder; the inverse direction of the team's 3-to-8 active-low decoder.
- Accepts 8 asynchronous active-low request lines and synchronizes them. Falling edges are latched into a pending register.
- Presents the highest-priority pending request as a 3-bit code with a valid/ack handshake.
- Sits between external request sources (buttons, peripheral strobes) and the control logic that consumes request codes.

Parameters:
N_REQ, 8, number of request lines; fixed at 8 for this revision.
CODE_W, 3, code width; equals log2(N_REQ).
SYNC_STAGES, 2, synchronizer flop depth; legal values 2..3.

Ports:
iClk  in  1  single system clock, rising edge.
iRst_n  in  1  asynchronous active-low reset.
iReq  in  8  request lines, active-low, asynchronous to iClk.
iEna  in  2  enables G1,G2; block is enabled only when iEna[1]=1 and iEna[0]=0.
iAck  in  1  consumer accepts the presented code; sampled only while oValid=1.
oCode  out  3  encoded request index; stable while oValid=1.
oValid  out  1  oCode holds a pending request.
oPending  out  8  current pending register, active-high.
oBusy  out  1  high when any pending bit is set.
oOverrun  out  8  sticky overrun flags; see Optional Feature.
iClrOvr  in  1  synchronous clear of oOverrun.

Behaviour:
- Reset (async assert, sync-released use):
  - synchronizer flops reset to all-ones (idle);
  - pending=0, oCode=0, oValid=0, oBusy=0, oOverrun=0;
  - FSM=IDLE.
- Synchronizer: SYNC_STAGES flops per line. A falling edge is detected as prev=1, cur=0 on the last stage.
- Pending set: a detected falling edge on bit i sets pending[i] on the next clock edge.
  - Edge capture is independent of iEna.
  - A line held low sets pending only once; it must return high before it can re-pend.
  - A pulse shorter than one clock period may be missed; this is not an error.
- Priority: highest index wins (bit 7 highest, bit 0 lowest).
- FSM:
  - IDLE: if enabled and pending!=0, latch oCode=index of highest pending bit, set oValid=1, go to PRESENT. Otherwise stay in IDLE.
  - PRESENT: oCode and oValid are held. A higher-priority bit pending in the meantime does NOT preempt.
  - PRESENT with iAck=1: clear pending[oCode], oValid=0, go to GAP.
  - GAP: one cycle with oValid=0, then go to IDLE. This guarantees a one-cycle valid deassertion between consecutive codes.
- Latency: first sampling edge with iReq[i] low is edge k. With SYNC_STAGES=2, oValid is high after edge k+SYNC_STAGES+1, i.e. visible in the cycle after edge k+3.
- Disable (iEna not 2'b10):
  - in IDLE: no presentation; pending keeps accumulating;
  - in PRESENT: the current code stays presented until acked.
- Ack in the same cycle as a new falling edge on bit oCode: set wins, so the bit re-pends and is re-presented after GAP.
- iAck outside PRESENT is ignored.
- oBusy = OR of pending, registered.
- oPending is the direct register value.

Optional Feature:
- Macro: REQ_ENCODER_OVERRUN_EN.
- Defined:
  - a falling edge on bit i while pending[i]=1 sets oOverrun[i];
  - flags are sticky until iClrOvr=1, which clears all flags at the next edge;
  - a coincident new overrun and iClrOvr resolve as set wins.
- Undefined: oOverrun is tied to 0, iClrOvr is ignored, and no overrun logic is synthesized.

Decomposition:
- Package req_encoder_pkg holds:
  - N_REQ and CODE_W constants;
  - FSM state type IDLE/PRESENT/GAP with a 2-bit encoding;
  - the ENABLE pattern constant 2'b10.
- One sub-module, sync_fall_detect: N_REQ-wide synchronizer plus falling-edge detector, parameterized by SYNC_STAGES, instantiated once.

Test Plan:
- Reset mid-PRESENT with code 4 → all outputs 0 immediately on iRst_n low; after release, iReq held high → oValid stays 0.
- iEna=2'b10, iReq[5] falls → oValid=1, oCode=5 in the cycle after edge k+3; iAck one cycle → oPending=0x00, oValid low for ≥1 cycle, no re-present while iReq[5] stays low.
- iReq[2] and iReq[6] fall in the same cycle → present 6; ack → after GAP present 2; ack → oBusy=0.
- iEna=2'b11, iReq[1] falls → oPending=0x02, oValid=0; set iEna=2'b10 → oValid=1, oCode=1 one cycle later.
- Presenting 3, iReq[3] released then re-falls so the edge lands in the ack cycle → pending[3] stays 1, code 3 re-presented after GAP.
- REQ_ENCODER_OVERRUN_EN defined, iReq[0] pulsed twice without ack → oOverrun=0x01; iClrOvr → 0x00. Macro undefined, same stimulus → oOverrun stays 0x00.
